// File: rtl/fetcher.sv
`default_nettype none
// ============================================================================
// Module  : fetcher
// Brief   : Instruction fetch stage with a direct-mapped I-cache and 2-bit BHT
// Revision: 1.0
// ============================================================================
module fetcher #(
  parameter int ICACHE_IDX_W = 6,
  parameter int BHT_IDX_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        global_full_sign,
  input  logic        rollback_sign_from_rob,
  input  logic [31:0] target_pc_from_rob,
  input  logic        bht_update_sign_from_rob,
  input  logic [31:0] bht_update_pc_from_rob,
  input  logic        bht_update_taken_from_rob,
  output logic        fetch_enable_to_mc,
  output logic [31:0] fetch_addr_to_mc,
  input  logic        fetch_done_from_mc,
  input  logic [31:0] inst_from_mc,
  output logic        finish_flag_to_dcd,
  output logic [31:0] inst_to_dcd,
  output logic [31:0] pc_to_dcd,
  output logic        predicted_jump_sign_to_dcd,
  output logic [31:0] rollback_pc_to_dcd
);
  localparam int         ICACHE_LINES = 1 << ICACHE_IDX_W;
  localparam int         BHT_ENTRIES  = 1 << BHT_IDX_W;
  localparam int         TAG_W        = 32 - ICACHE_IDX_W - 2;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        fetch_enable_q, fetch_enable_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        finish_q, finish_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        pred_q, pred_d;
  logic [31:0] rb_pc_q, rb_pc_d;

  logic [ICACHE_LINES-1:0] valid_q;
  logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];
  logic [1:0]              bht_q  [BHT_ENTRIES];

  logic [ICACHE_IDX_W-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0]        pc_tag, fill_tag;
  logic                    hit, fill_en, emit;
  logic [BHT_IDX_W-1:0]    bht_lookup_idx, bht_upd_idx;
  logic [1:0]              bht_ctr, bht_upd_cur, bht_upd_ctr;
  logic [31:0]             emit_inst, j_imm, b_imm, pc_plus4, pred_next, pred_rb;
  logic                    pred_taken;
  logic                    unused_bits;

  assign pc_idx         = pc_q[ICACHE_IDX_W+1:2];
  assign pc_tag         = pc_q[31:ICACHE_IDX_W+2];
  assign hit            = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  // Fill uses the request address: pc may have moved on after a rollback.
  assign fill_idx       = fetch_addr_q[ICACHE_IDX_W+1:2];
  assign fill_tag       = fetch_addr_q[31:ICACHE_IDX_W+2];
  assign bht_lookup_idx = pc_q[BHT_IDX_W+1:2];
  assign bht_ctr        = bht_q[bht_lookup_idx];
  assign bht_upd_idx    = bht_update_pc_from_rob[BHT_IDX_W+1:2];
  assign bht_upd_cur    = bht_q[bht_upd_idx];
  assign unused_bits    = ^{bht_update_pc_from_rob[31:BHT_IDX_W+2], bht_update_pc_from_rob[1:0]};

  always_comb begin
    bht_upd_ctr = bht_upd_cur;
    if (bht_update_taken_from_rob) begin
      if (bht_upd_cur != 2'b11) bht_upd_ctr = bht_upd_cur + 2'b01;
    end else begin
      if (bht_upd_cur != 2'b00) bht_upd_ctr = bht_upd_cur - 2'b01;
    end
  end

  always_comb begin
    emit_inst  = (state_q == WAIT_MEM) ? inst_from_mc : data_q[pc_idx];
    j_imm      = {{11{emit_inst[31]}}, emit_inst[31], emit_inst[19:12], emit_inst[20],
                  emit_inst[30:21], 1'b0};
    b_imm      = {{19{emit_inst[31]}}, emit_inst[31], emit_inst[7], emit_inst[30:25],
                  emit_inst[11:8], 1'b0};
    pc_plus4   = pc_q + 32'd4;
    pred_taken = 1'b0;
    pred_next  = pc_plus4;
    pred_rb    = pc_plus4;
    case (emit_inst[6:0])
      OP_JAL: begin
        pred_taken = 1'b1;
        pred_next  = pc_q + j_imm;
      end
      OP_BRANCH: begin
        if (bht_ctr[1]) begin
          pred_taken = 1'b1;
          pred_next  = pc_q + b_imm;
        end else begin
          pred_rb = pc_q + b_imm;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    discard_d      = discard_q;
    fetch_enable_d = fetch_enable_q;
    fetch_addr_d   = fetch_addr_q;
    finish_d       = finish_q;
    inst_out_d     = inst_out_q;
    pc_out_d       = pc_out_q;
    pred_d         = pred_q;
    rb_pc_d        = rb_pc_q;
    fill_en        = 1'b0;
    emit           = 1'b0;
    if (rdy) begin
      finish_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (rollback_sign_from_rob) begin
            pc_d = target_pc_from_rob;
          end else if (!global_full_sign) begin
            if (hit) begin
              emit = 1'b1;
            end else begin
              fetch_enable_d = 1'b1;
              fetch_addr_d   = pc_q;
              state_d        = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (rollback_sign_from_rob) begin
            pc_d      = target_pc_from_rob;
            discard_d = 1'b1;
          end
          if (fetch_done_from_mc) begin
            fetch_enable_d = 1'b0;
            fill_en        = 1'b1;
            state_d        = IDLE;
            discard_d      = 1'b0;
            if (!discard_q && !rollback_sign_from_rob) emit = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (emit) begin
        finish_d   = 1'b1;
        inst_out_d = emit_inst;
        pc_out_d   = pc_q;
        pred_d     = pred_taken;
        rb_pc_d    = pred_rb;
        pc_d       = pred_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= 32'd0;
      discard_q      <= 1'b0;
      fetch_enable_q <= 1'b0;
      fetch_addr_q   <= 32'd0;
      finish_q       <= 1'b0;
      inst_out_q     <= 32'd0;
      pc_out_q       <= 32'd0;
      pred_q         <= 1'b0;
      rb_pc_q        <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      discard_q      <= discard_d;
      fetch_enable_q <= fetch_enable_d;
      fetch_addr_q   <= fetch_addr_d;
      finish_q       <= finish_d;
      inst_out_q     <= inst_out_d;
      pc_out_q       <= pc_out_d;
      pred_q         <= pred_d;
      rb_pc_q        <= rb_pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (rdy) begin
      if (bht_update_sign_from_rob) bht_q[bht_upd_idx] <= bht_upd_ctr;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= inst_from_mc;
    end
  end

  assign fetch_enable_to_mc         = fetch_enable_q;
  assign fetch_addr_to_mc           = fetch_addr_q;
  assign finish_flag_to_dcd         = finish_q;
  assign inst_to_dcd                = inst_out_q;
  assign pc_to_dcd                  = pc_out_q;
  assign predicted_jump_sign_to_dcd = pred_q;
  assign rollback_pc_to_dcd         = rb_pc_q;
endmodule
`default_nettype wire

// File: tb/tb_fetcher.sv
`default_nettype none
// Directed bench for fetcher: cold miss, hits, BHT prediction, rollback, stalls, reset.
module tb_fetcher;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        full = 1'b0;
  logic        rb = 1'b0;
  logic [31:0] rb_target = 32'd0;
  logic        bht_upd = 1'b0;
  logic [31:0] bht_pc = 32'd0;
  logic        bht_taken = 1'b0;
  logic        done = 1'b0;
  logic [31:0] mem_inst = 32'd0;
  logic        fetch_enable_to_mc;
  logic [31:0] fetch_addr_to_mc;
  logic        finish_flag_to_dcd;
  logic [31:0] inst_to_dcd;
  logic [31:0] pc_to_dcd;
  logic        predicted_jump_sign_to_dcd;
  logic [31:0] rollback_pc_to_dcd;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JAL_M4   = 32'hFFDF_F06F;
  localparam logic [31:0] JAL_P16  = 32'h0100_006F;
  localparam logic [31:0] BEQ_P16  = 32'h0000_0863;

  fetcher dut (
    .clk                        (clk),
    .rst                        (rst),
    .rdy                        (rdy),
    .global_full_sign           (full),
    .rollback_sign_from_rob     (rb),
    .target_pc_from_rob         (rb_target),
    .bht_update_sign_from_rob   (bht_upd),
    .bht_update_pc_from_rob     (bht_pc),
    .bht_update_taken_from_rob  (bht_taken),
    .fetch_enable_to_mc         (fetch_enable_to_mc),
    .fetch_addr_to_mc           (fetch_addr_to_mc),
    .fetch_done_from_mc         (done),
    .inst_from_mc               (mem_inst),
    .finish_flag_to_dcd         (finish_flag_to_dcd),
    .inst_to_dcd                (inst_to_dcd),
    .pc_to_dcd                  (pc_to_dcd),
    .predicted_jump_sign_to_dcd (predicted_jump_sign_to_dcd),
    .rollback_pc_to_dcd         (rollback_pc_to_dcd)
  );

  always #5 clk = ~clk;

  // {finish, inst, pc, pred, rollback_pc} and {enable, addr}
  wire [97:0] emit_bus = {finish_flag_to_dcd, inst_to_dcd, pc_to_dcd,
                          predicted_jump_sign_to_dcd, rollback_pc_to_dcd};
  wire [32:0] req_bus  = {fetch_enable_to_mc, fetch_addr_to_mc};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (emit_bus !== 98'h0) begin
      $display("FAIL reset_emit: got %h want 0", emit_bus); miscompares++;
    end
    vectors++;
    if (req_bus !== 33'h0) begin
      $display("FAIL reset_req: got %h want 0", req_bus); miscompares++;
    end
    step();
    step();
    rst = 1'b0;
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h0} || finish_flag_to_dcd !== 1'b0) begin
      $display("FAIL cold_req0: got %h fin %b want 100000000 fin 0", req_bus, finish_flag_to_dcd);
      miscompares++;
    end
  endtask

  task automatic test_cold_miss();
    done = 1'b1; mem_inst = NOP;
    step();
    vectors++;
    if (emit_bus !== {1'b1, NOP, 32'h0, 1'b0, 32'h4} || fetch_enable_to_mc !== 1'b0) begin
      $display("FAIL cold_emit: got %h en %b want %h en 0", emit_bus, fetch_enable_to_mc,
               {1'b1, NOP, 32'h0, 1'b0, 32'h4});
      miscompares++;
    end
    done = 1'b0;
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h4} || finish_flag_to_dcd !== 1'b0) begin
      $display("FAIL next_req4: got %h fin %b want 100000004 fin 0", req_bus, finish_flag_to_dcd);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [97:0] exp;
    done = 1'b1; mem_inst = JAL_M4;
    step();
    vectors++;
    if (emit_bus !== {1'b1, JAL_M4, 32'h4, 1'b1, 32'h8}) begin
      $display("FAIL jal_emit: got %h want %h", emit_bus, {1'b1, JAL_M4, 32'h4, 1'b1, 32'h8});
      miscompares++;
    end
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = (i % 2 == 0) ? {1'b1, NOP, 32'h0, 1'b0, 32'h4} : {1'b1, JAL_M4, 32'h4, 1'b1, 32'h8};
      vectors++;
      if (emit_bus !== exp || fetch_enable_to_mc !== 1'b0) begin
        $display("FAIL hit_b2b[%0d]: got %h en %b want %h en 0", i, emit_bus,
                 fetch_enable_to_mc, exp);
        miscompares++;
      end
    end
    rb = 1'b1; rb_target = 32'h20;
    step();
    vectors++;
    if (finish_flag_to_dcd !== 1'b0 || fetch_enable_to_mc !== 1'b0) begin
      $display("FAIL idle_rollback: got fin %b en %b want 0 0", finish_flag_to_dcd,
               fetch_enable_to_mc);
      miscompares++;
    end
    rb = 1'b0;
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h20}) begin
      $display("FAIL req20: got %h want 100000020", req_bus); miscompares++;
    end
  endtask

  task automatic test_branch();
    done = 1'b1; mem_inst = BEQ_P16;
    step();
    vectors++;
    if (emit_bus !== {1'b1, BEQ_P16, 32'h20, 1'b0, 32'h30}) begin
      $display("FAIL beq_nt: got %h want %h", emit_bus, {1'b1, BEQ_P16, 32'h20, 1'b0, 32'h30});
      miscompares++;
    end
    done = 1'b0;
    bht_upd = 1'b1; bht_pc = 32'h20; bht_taken = 1'b1;
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h24}) begin
      $display("FAIL req24: got %h want 100000024", req_bus); miscompares++;
    end
    step();
    bht_upd = 1'b0;
    done = 1'b1; mem_inst = JAL_M4;
    step();
    vectors++;
    if (emit_bus !== {1'b1, JAL_M4, 32'h24, 1'b1, 32'h28}) begin
      $display("FAIL jal24_emit: got %h want %h", emit_bus, {1'b1, JAL_M4, 32'h24, 1'b1, 32'h28});
      miscompares++;
    end
    done = 1'b0;
    step();
    vectors++;
    if (emit_bus !== {1'b1, BEQ_P16, 32'h20, 1'b1, 32'h24} || fetch_enable_to_mc !== 1'b0) begin
      $display("FAIL beq_t: got %h en %b want %h en 0", emit_bus, fetch_enable_to_mc,
               {1'b1, BEQ_P16, 32'h20, 1'b1, 32'h24});
      miscompares++;
    end
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h30}) begin
      $display("FAIL req30: got %h want 100000030", req_bus); miscompares++;
    end
  endtask

  task automatic test_rollback_mem();
    done = 1'b1; mem_inst = JAL_P16;
    step();
    vectors++;
    if (emit_bus !== {1'b1, JAL_P16, 32'h30, 1'b1, 32'h34}) begin
      $display("FAIL jal30_emit: got %h want %h", emit_bus, {1'b1, JAL_P16, 32'h30, 1'b1, 32'h34});
      miscompares++;
    end
    done = 1'b0;
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h40}) begin
      $display("FAIL req40: got %h want 100000040", req_bus); miscompares++;
    end
    rb = 1'b1; rb_target = 32'h100;
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h40} || finish_flag_to_dcd !== 1'b0) begin
      $display("FAIL rb_hold_req: got %h fin %b want 100000040 fin 0", req_bus, finish_flag_to_dcd);
      miscompares++;
    end
    rb = 1'b0;
    done = 1'b1; mem_inst = NOP;
    step();
    vectors++;
    if (finish_flag_to_dcd !== 1'b0 || fetch_enable_to_mc !== 1'b0) begin
      $display("FAIL discard40: got fin %b en %b want 0 0", finish_flag_to_dcd, fetch_enable_to_mc);
      miscompares++;
    end
    done = 1'b0;
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h100}) begin
      $display("FAIL req100: got %h want 100000100", req_bus); miscompares++;
    end
    rb = 1'b1; rb_target = 32'h40;
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h100}) begin
      $display("FAIL rb_hold_req100: got %h want 100000100", req_bus); miscompares++;
    end
    rb = 1'b0;
    done = 1'b1; mem_inst = NOP;
    step();
    vectors++;
    if (finish_flag_to_dcd !== 1'b0 || fetch_enable_to_mc !== 1'b0) begin
      $display("FAIL discard100: got fin %b en %b want 0 0", finish_flag_to_dcd, fetch_enable_to_mc);
      miscompares++;
    end
    done = 1'b0;
  endtask

  task automatic test_global_full();
    full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (finish_flag_to_dcd !== 1'b0 || fetch_enable_to_mc !== 1'b0) begin
        $display("FAIL full_hold[%0d]: got fin %b en %b want 0 0", i, finish_flag_to_dcd,
                 fetch_enable_to_mc);
        miscompares++;
      end
    end
    full = 1'b0;
    step();
    vectors++;
    if (emit_bus !== {1'b1, NOP, 32'h40, 1'b0, 32'h44} || fetch_enable_to_mc !== 1'b0) begin
      $display("FAIL full_release: got %h en %b want %h en 0", emit_bus, fetch_enable_to_mc,
               {1'b1, NOP, 32'h40, 1'b0, 32'h44});
      miscompares++;
    end
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h44}) begin
      $display("FAIL req44: got %h want 100000044", req_bus); miscompares++;
    end
  endtask

  task automatic test_rdy_stall();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (req_bus !== {1'b1, 32'h44} || emit_bus !== {1'b0, NOP, 32'h40, 1'b0, 32'h44}) begin
        $display("FAIL stall[%0d]: got req %h emit %h want 100000044 %h", i, req_bus, emit_bus,
                 {1'b0, NOP, 32'h40, 1'b0, 32'h44});
        miscompares++;
      end
    end
    rdy = 1'b1;
    done = 1'b1; mem_inst = NOP;
    step();
    vectors++;
    if (emit_bus !== {1'b1, NOP, 32'h44, 1'b0, 32'h48}) begin
      $display("FAIL stall_emit: got %h want %h", emit_bus, {1'b1, NOP, 32'h44, 1'b0, 32'h48});
      miscompares++;
    end
    done = 1'b0;
    step();
    vectors++;
    if (finish_flag_to_dcd !== 1'b0 || req_bus !== {1'b1, 32'h48}) begin
      $display("FAIL stall_once: got fin %b req %h want fin 0 req 100000048",
               finish_flag_to_dcd, req_bus);
      miscompares++;
    end
  endtask

  task automatic test_async_reset();
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (fetch_enable_to_mc !== 1'b0 || emit_bus !== 98'h0) begin
      $display("FAIL async_rst: got en %b emit %h want en 0 emit 0", fetch_enable_to_mc, emit_bus);
      miscompares++;
    end
    step();
    rst = 1'b0;
    done = 1'b1; mem_inst = JAL_M4;
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h0} || finish_flag_to_dcd !== 1'b0) begin
      $display("FAIL late_done: got req %h fin %b want 100000000 fin 0", req_bus, finish_flag_to_dcd);
      miscompares++;
    end
    done = 1'b0;
    step();
    vectors++;
    if (req_bus !== {1'b1, 32'h0} || finish_flag_to_dcd !== 1'b0) begin
      $display("FAIL post_rst_wait: got req %h fin %b want 100000000 fin 0", req_bus,
               finish_flag_to_dcd);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_branch();
    test_rollback_mem();
    test_global_full();
    test_rdy_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire
